// File: rtl/lm32_dtlb_refill.sv
// Purpose : hardware DTLB refill walker; two-level page-table walk over a Wishbone
//           read master, then loads the entry via TLB_VADDRESS/TLB_PADDRESS CSR writes.
// Latency : zero-wait bus, miss to done = 6 cycles (5 on a superpage leaf).
// Backpressure: each Wishbone read is held until ack/err; a miss is accepted in IDLE only.
//
// Ports
//   clk_i, rst_i (async, active-low)
//   enable, miss, miss_address, ptbr           : walk request side
//   d_adr_o, d_cyc_o, d_stb_o, d_we_o, d_sel_o,
//   d_dat_i, d_ack_i, d_err_i                  : Wishbone read master
//   csr, csr_write_data, csr_write_enable      : DTLB update CSR initiator
//   busy, done, fault, fault_address           : status to the core
//
// Build option: define LM32_DTLB_REFILL_SUPERPAGE_EN to treat a valid L1 PTE with
// bit1 set as a 4 MiB leaf (no L2 read). Without it bit1 is ignored.

module lm32_dtlb_refill #(
    parameter int page_bits = 12,
    parameter int l1_bits   = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable,
    input  logic        miss,
    input  logic [31:0] miss_address,
    input  logic [31:0] ptbr,
    output logic [31:0] d_adr_o,
    output logic        d_cyc_o,
    output logic        d_stb_o,
    output logic        d_we_o,
    output logic [3:0]  d_sel_o,
    input  logic [31:0] d_dat_i,
    input  logic        d_ack_i,
    input  logic        d_err_i,
    output logic [4:0]  csr,
    output logic [31:0] csr_write_data,
    output logic        csr_write_enable,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] fault_address
);

    // CSR indices of the TLB update registers.
    localparam logic [4:0] CSR_TLB_VADDRESS = 5'h11;
    localparam logic [4:0] CSR_TLB_PADDRESS = 5'h12;

    // Width of the L2 index field, vaddr[31-l1_bits:page_bits].
    localparam int L2_BITS  = 32 - l1_bits - page_bits;
    localparam int PFN_BITS = 32 - page_bits;

`ifdef LM32_DTLB_REFILL_SUPERPAGE_EN
    localparam bit SUPERPAGE = 1'b1;
`else
    localparam bit SUPERPAGE = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1,
        S_L2,
        S_WR_V,
        S_WR_P,
        S_FLT
    } state_t;

    state_t              state;
    logic [31:0]         va;
    logic [PFN_BITS-1:0] pfn;

    // PTE decode of the word currently on the bus.
    logic pte_valid;
    logic pte_leaf;
    logic bus_fail;
    assign pte_valid = d_dat_i[0];
    assign pte_leaf  = SUPERPAGE && d_dat_i[1];
    // A bus error always wins over a simultaneous ack.
    assign bus_fail  = d_err_i || (d_ack_i && !pte_valid);

    // Read-only master: strobe mirrors cycle, full-word select, never writes.
    assign d_stb_o = d_cyc_o;
    assign d_we_o  = 1'b0;
    assign d_sel_o = 4'hF;

    // Low ptbr bits and PTE flag/reserved bits carry no information for the walk.
    logic unused_ok;
    assign unused_ok = ^{ptbr[l1_bits+1:0], d_dat_i};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state            <= S_IDLE;
            va               <= '0;
            pfn              <= '0;
            d_adr_o          <= '0;
            d_cyc_o          <= 1'b0;
            csr              <= '0;
            csr_write_data   <= '0;
            csr_write_enable <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            fault            <= 1'b0;
            fault_address    <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            csr_write_enable <= 1'b0;
            done             <= 1'b0;
            fault            <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (enable && miss) begin
                        va    <= miss_address;
                        busy  <= 1'b1;
                        state <= S_L1;
                    end
                end

                S_L1: begin
                    if (!d_cyc_o) begin
                        // First cycle in L1: launch the L1 descriptor read.
                        d_cyc_o <= 1'b1;
                        d_adr_o <= {ptbr[31:l1_bits+2], va[31 -: l1_bits], 2'b00};
                    end else if (bus_fail) begin
                        d_cyc_o <= 1'b0;
                        state   <= S_FLT;
                    end else if (d_ack_i) begin
                        if (pte_leaf) begin
                            // Superpage: frame bits above the L1 index come from the
                            // PTE, the L2 index bits pass straight through from va.
                            d_cyc_o          <= 1'b0;
                            pfn              <= {d_dat_i[31 -: l1_bits], va[page_bits +: L2_BITS]};
                            csr              <= CSR_TLB_VADDRESS;
                            csr_write_data   <= {va[31:page_bits], {(page_bits-1){1'b0}}, 1'b1};
                            csr_write_enable <= 1'b1;
                            state            <= S_WR_V;
                        end else begin
                            // Keep the cycle open and chain straight into the L2 read.
                            d_adr_o <= {d_dat_i[31:L2_BITS+2], va[page_bits +: L2_BITS], 2'b00};
                            state   <= S_L2;
                        end
                    end
                end

                S_L2: begin
                    if (bus_fail) begin
                        d_cyc_o <= 1'b0;
                        state   <= S_FLT;
                    end else if (d_ack_i) begin
                        d_cyc_o          <= 1'b0;
                        pfn              <= d_dat_i[31:page_bits];
                        csr              <= CSR_TLB_VADDRESS;
                        csr_write_data   <= {va[31:page_bits], {(page_bits-1){1'b0}}, 1'b1};
                        csr_write_enable <= 1'b1;
                        state            <= S_WR_V;
                    end
                end

                S_WR_V: begin
                    // VADDRESS write is on the bus this cycle; queue PADDRESS next.
                    csr              <= CSR_TLB_PADDRESS;
                    csr_write_data   <= {pfn, {(page_bits-1){1'b0}}, 1'b1};
                    csr_write_enable <= 1'b1;
                    state            <= S_WR_P;
                end

                S_WR_P: begin
                    // done and the busy drop land on the first IDLE cycle.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                S_FLT: begin
                    fault         <= 1'b1;
                    fault_address <= va;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end

                default: begin
                    d_cyc_o <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
